// File: rtl/clock_pkg.sv
// Shared state encoding and counter limits for the settable clock.
package clock_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      SET_MIN  = 2'd1,
      SET_HOUR = 2'd2
   } state_t;

   localparam logic [5:0] SEC_MAX = 6'd59;
   localparam logic [5:0] MIN_MAX = 6'd59;

endpackage

// File: rtl/edge_det.sv
// One-bit rising-edge detector for an already-synchronized button level.
module edge_det (
   input  logic clk,
   input  logic rst,
   input  logic i_lvl,
   output logic o_rise
);

   logic r_prev;

   // Previous level resets high so a button held through reset is not a press.
   always_ff @(posedge clk) begin
      if (!rst) r_prev <= 1'b1;
      else      r_prev <= i_lvl;
   end

   assign o_rise = i_lvl & ~r_prev;

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-of-day counter with a three-state mode/set FSM and blinking digit enables.
module clock_set_ctrl
   import clock_pkg::*;
#(
   parameter int unsigned HOUR_MAX = 23
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_1hz,
   input  logic       btn_mode,
   input  logic       btn_inc,
   output logic [5:0] sec_o,
   output logic [5:0] min_o,
   output logic [4:0] hour_o,
   output logic [1:0] mode_o,
   output logic       min_en_o,
   output logic       hour_en_o
);

   localparam logic [4:0] HOUR_MAX_L = 5'(HOUR_MAX);

   function automatic logic [5:0] inc6(input logic [5:0] v, input logic [5:0] m);
      return (v == m) ? 6'd0 : v + 6'd1;
   endfunction

   function automatic logic [4:0] inc5(input logic [4:0] v, input logic [4:0] m);
      return (v == m) ? 5'd0 : v + 5'd1;
   endfunction

   logic       w_mode_p, w_inc_p;
   state_t     r_state, w_state_n;
   logic [5:0] r_sec, r_min, w_sec_n, w_min_n;
   logic [4:0] r_hour, w_hour_n;
   logic       r_blink, w_blink_n;
   logic       r_min_en, r_hour_en, w_min_en_n, w_hour_en_n;

   edge_det u_mode_edge (.clk(clk), .rst(rst), .i_lvl(btn_mode), .o_rise(w_mode_p));
   edge_det u_inc_edge  (.clk(clk), .rst(rst), .i_lvl(btn_inc),  .o_rise(w_inc_p));

   always_comb begin
      w_state_n = r_state;
      w_sec_n   = r_sec;
      w_min_n   = r_min;
      w_hour_n  = r_hour;
      case (r_state)
         RUN: begin
            if (w_mode_p) begin
               w_state_n = SET_MIN;
               w_sec_n   = 6'd0;
            end else if (tick_1hz) begin
               w_sec_n = inc6(r_sec, SEC_MAX);
               if (r_sec == SEC_MAX) begin
                  w_min_n = inc6(r_min, MIN_MAX);
                  if (r_min == MIN_MAX) w_hour_n = inc5(r_hour, HOUR_MAX_L);
               end
            end
         end
         SET_MIN: begin
            if (w_mode_p)     w_state_n = SET_HOUR;
            else if (w_inc_p) w_min_n   = inc6(r_min, MIN_MAX);
         end
         SET_HOUR: begin
            if (w_mode_p)     w_state_n = RUN;
            else if (w_inc_p) w_hour_n  = inc5(r_hour, HOUR_MAX_L);
         end
         default: w_state_n = RUN;
      endcase
   end

   // Blink phase restarts lit on every mode change so the edited field is visible immediately.
   always_comb begin
      w_blink_n = r_blink;
      if (w_mode_p)                        w_blink_n = 1'b1;
      else if (tick_1hz && r_state != RUN) w_blink_n = ~r_blink;
      w_min_en_n  = (w_state_n == SET_MIN)  ? w_blink_n : 1'b1;
      w_hour_en_n = (w_state_n == SET_HOUR) ? w_blink_n : 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state   <= RUN;
         r_sec     <= 6'd0;
         r_min     <= 6'd0;
         r_hour    <= 5'd0;
         r_blink   <= 1'b1;
         r_min_en  <= 1'b1;
         r_hour_en <= 1'b1;
      end else begin
         r_state   <= w_state_n;
         r_sec     <= w_sec_n;
         r_min     <= w_min_n;
         r_hour    <= w_hour_n;
         r_blink   <= w_blink_n;
         r_min_en  <= w_min_en_n;
         r_hour_en <= w_hour_en_n;
      end
   end

   assign sec_o     = r_sec;
   assign min_o     = r_min;
   assign hour_o    = r_hour;
   assign mode_o    = r_state;
   assign min_en_o  = r_min_en;
   assign hour_en_o = r_hour_en;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with hand-computed expectations.
module tb_clock_set_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       tick_1hz = 1'b0;
   logic       btn_mode = 1'b0;
   logic       btn_inc = 1'b0;
   logic [5:0] sec_o, min_o;
   logic [4:0] hour_o;
   logic [1:0] mode_o;
   logic       min_en_o, hour_en_o;

   int n_tests = 0;
   int n_fail  = 0;

   clock_set_ctrl #(.HOUR_MAX(23)) dut (
      .clk(clk), .rst(rst), .tick_1hz(tick_1hz),
      .btn_mode(btn_mode), .btn_inc(btn_inc),
      .sec_o(sec_o), .min_o(min_o), .hour_o(hour_o),
      .mode_o(mode_o), .min_en_o(min_en_o), .hour_en_o(hour_en_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         tick_1hz = 1'b1; cyc(1);
         tick_1hz = 1'b0; cyc(1);
      end
   endtask

   task automatic press_mode();
      btn_mode = 1'b1; cyc(1);
      btn_mode = 1'b0; cyc(1);
   endtask

   task automatic press_inc(input int n);
      for (int i = 0; i < n; i++) begin
         btn_inc = 1'b1; cyc(1);
         btn_inc = 1'b0; cyc(1);
      end
   endtask

   task automatic chk_all(input string tag, input int s, input int m, input int h,
                          input int md, input int me, input int he);
      chk({tag, ".sec"},     sec_o,     s);
      chk({tag, ".min"},     min_o,     m);
      chk({tag, ".hour"},    hour_o,    h);
      chk({tag, ".mode"},    mode_o,    md);
      chk({tag, ".min_en"},  min_en_o,  me);
      chk({tag, ".hour_en"}, hour_en_o, he);
   endtask

   initial begin
      cyc(2);
      chk_all("reset", 0, 0, 0, 0, 1, 1);
      rst = 1'b1;
      cyc(1);

      tick(61);
      chk_all("run61", 1, 1, 0, 0, 1, 1);

      press_inc(1);
      chk_all("run_inc_ignored", 1, 1, 0, 0, 1, 1);

      // preload 23:59:59
      press_mode();
      chk_all("enter_setmin", 0, 1, 0, 1, 1, 1);
      press_inc(58);
      chk("setmin_59", min_o, 59);
      press_mode();
      chk_all("enter_sethour", 0, 59, 0, 2, 1, 1);
      press_inc(23);
      chk("sethour_23", hour_o, 23);
      press_inc(1);
      chk("sethour_wrap", hour_o, 0);
      press_inc(23);
      press_mode();
      tick(59);
      chk_all("preload", 59, 59, 23, 0, 1, 1);
      tick(1);
      chk_all("midnight", 0, 0, 0, 0, 1, 1);

      // tick and mode press in the same cycle
      tick(5);
      chk("sec5", sec_o, 5);
      tick_1hz = 1'b1; btn_mode = 1'b1; cyc(1);
      tick_1hz = 1'b0; btn_mode = 1'b0; cyc(1);
      chk_all("tick_mode_same", 0, 0, 0, 1, 1, 1);
      press_inc(58);
      chk("min58", min_o, 58);
      press_inc(3);
      chk_all("min_wrap", 0, 1, 0, 1, 1, 1);
      tick(1);
      chk_all("setmin_tick1", 0, 1, 0, 1, 0, 1);
      tick(1);
      chk_all("setmin_tick2", 0, 1, 0, 1, 1, 1);

      // mode and inc pressed together
      btn_mode = 1'b1; btn_inc = 1'b1; cyc(1);
      btn_mode = 1'b0; btn_inc = 1'b0; cyc(1);
      chk_all("mode_inc_same", 0, 1, 0, 2, 1, 1);

      tick(1);
      chk_all("sethour_t1", 0, 1, 0, 2, 1, 0);
      tick(1);
      chk_all("sethour_t2", 0, 1, 0, 2, 1, 1);
      tick(1);
      chk_all("sethour_t3", 0, 1, 0, 2, 1, 0);
      tick(1);
      chk_all("sethour_t4", 0, 1, 0, 2, 1, 1);

      btn_inc = 1'b1; cyc(10);
      btn_inc = 1'b0; cyc(1);
      chk("inc_held", hour_o, 1);

      // reset mid-set with mode button held through release
      btn_mode = 1'b1; rst = 1'b0; cyc(2);
      chk_all("rst_mid", 0, 0, 0, 0, 1, 1);
      rst = 1'b1; cyc(3);
      chk_all("rst_held_btn", 0, 0, 0, 0, 1, 1);
      btn_mode = 1'b0; cyc(2);
      chk_all("rst_released", 0, 0, 0, 0, 1, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/clock_set_ctrl.md
CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 Parameter: HOUR_MAX, default 23, last hour value before wrap to 0 (legal range 1..31).
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low; sampled on rising clk edge.
REQ-004 tick_1hz  input  1  one-clk-cycle pulse once per second, from an upstream divider.
REQ-005 btn_mode  input  1  mode button level, already synchronized and debounced, active-high.
REQ-006 btn_inc  input  1  increment button level, already synchronized and debounced, active-high.
REQ-007 sec_o  output  6  seconds, binary, 0..59, registered.
REQ-008 min_o  output  6  minutes, binary, 0..59, registered.
REQ-009 hour_o  output  5  hours, binary, 0..HOUR_MAX, registered.
REQ-010 mode_o  output  2  current state: 0 RUN, 1 SET_MIN, 2 SET_HOUR, registered.
REQ-011 min_en_o  output  1  display enable for minute digits, registered.
REQ-012 hour_en_o  output  1  display enable for hour digits, registered.

Function
REQ-013 The block SHALL detect a press as a rising edge of btn_mode or btn_inc: level 1 this cycle and 0 the previous cycle; holding a button SHALL produce exactly one press.
REQ-014 The FSM SHALL have states RUN, SET_MIN and SET_HOUR; a mode press SHALL move RUN->SET_MIN->SET_HOUR->RUN.
REQ-015 All outputs SHALL reflect an event one clk cycle after the cycle in which the press or tick is sampled.
REQ-016 In RUN, each tick_1hz SHALL increment sec_o.
REQ-017 In RUN, sec_o 59 SHALL wrap to 0 and carry +1 to min_o.
REQ-018 In RUN, min_o 59 with a carry SHALL wrap to 0 and carry +1 to hour_o.
REQ-019 In RUN, hour_o HOUR_MAX with a carry SHALL wrap to 0, so HOUR_MAX:59:59 plus one tick gives 00:00:00.
REQ-020 In SET_MIN and SET_HOUR, tick_1hz SHALL NOT change sec_o, min_o or hour_o.
REQ-021 The transition RUN->SET_MIN SHALL clear sec_o to 0.
REQ-022 In SET_MIN, an inc press SHALL increment min_o, wrapping 59->0 with no carry into hour_o.
REQ-023 In SET_HOUR, an inc press SHALL increment hour_o, wrapping HOUR_MAX->0.
REQ-024 In RUN, an inc press SHALL be ignored.
REQ-025 If mode and inc presses occur in the same cycle, the mode press SHALL win and the inc press SHALL be discarded.
REQ-026 If a tick and a mode press RUN->SET_MIN occur in the same cycle, the state change SHALL win and sec_o SHALL become 0.
REQ-027 A blink phase bit SHALL toggle on every tick_1hz while in SET_MIN or SET_HOUR.
REQ-028 The blink phase bit SHALL be forced to 1 on every state change.
REQ-029 In SET_MIN, min_en_o SHALL equal the blink phase; in SET_HOUR, hour_en_o SHALL equal the blink phase.
REQ-030 Any display enable not selected by REQ-029 SHALL be 1.
REQ-031 All counter arithmetic SHALL compare at the maximum before incrementing, so no out-of-range value ever appears on an output.

Reset
REQ-032 While rst=0 at a clk edge: sec_o=0, min_o=0, hour_o=0, mode_o=RUN, min_en_o=1, hour_en_o=1, blink phase=1.
REQ-033 Previous-level edge registers SHALL reset to 1, so a button held through reset SHALL NOT generate a press.
REQ-034 Reset SHALL take priority over every press and tick in the same cycle, including a reset asserted in mid-set.

Structure
REQ-035 Package clock_pkg SHALL hold the state encoding (RUN/SET_MIN/SET_HOUR) and the constants SEC_MAX=59 and MIN_MAX=59.
REQ-036 Sub-module edge_det SHALL provide a one-bit rising-edge detector with clk/rst, instantiated once per button.
REQ-037 The FSM, counters and blink logic SHALL live in clock_set_ctrl.

Verification
REQ-038 Reset, then 61 ticks in RUN -> sec_o=1, min_o=1, hour_o=0, both enables 1.
REQ-039 Preload 23:59:59 through the set sequence, then 1 tick -> 00:00:00.
REQ-040 Mode press, then 3 inc presses with min_o=58 -> min_o=1, hour_o unchanged, sec_o=0, mode_o=1.
REQ-041 Same-cycle mode and inc press in SET_MIN -> mode_o=2, min_o unchanged.
REQ-042 In SET_HOUR, 4 ticks -> hour_en_o sequence 0,1,0,1 and min_en_o=1 throughout; btn_inc held 10 cycles -> hour_o +1 only.
REQ-043 rst=0 mid-SET_HOUR with btn_mode held through release -> all outputs at REQ-032 values and no press detected after release.
